// File: rtl/ex_stage_unit_if.sv
// Execute-stage bus: operands and controls toward the EX unit, results and
// redirect outputs back from it.
interface ex_stage_unit_if #(
  parameter int XLEN = 32
);
  logic [3:0]      alu_op;
  logic [XLEN-1:0] in_1;
  logic [XLEN-1:0] in_2;
  logic [2:0]      branch;
  logic            jalr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] alu_out;
  logic            zero;
  logic            carry;
  logic            overflow;
  logic            sign;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] alu_out_q;

  modport master (
    output alu_op, in_1, in_2, branch, jalr, pc, imm, rs1,
    input  alu_out, zero, carry, overflow, sign, taken, target, alu_out_q
  );

  modport slave (
    input  alu_op, in_1, in_2, branch, jalr, pc, imm, rs1,
    output alu_out, zero, carry, overflow, sign, taken, target, alu_out_q
  );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute-stage compute block: ALU with flags, branch-condition evaluation,
// branch/jump target generation and a registered ALU result for EX/MEM.
module ex_stage_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  ex_stage_unit_if.slave bus
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLL    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_SLT    = 4'd8;
  localparam logic [3:0] OP_SLTU   = 4'd9;
  localparam logic [3:0] OP_PASS_B = 4'd10;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_NONE = 3'd2;
  localparam logic [2:0] BR_JUMP = 3'd3;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  localparam int MSB = XLEN - 1;

  logic            sub_s;
  logic            arith_s;
  logic [XLEN-1:0] b_eff_s;
  logic [XLEN:0]   sum_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] result_s;
  logic            zero_s;
  logic            sign_s;
  logic            carry_s;
  logic            overflow_s;
  logic            taken_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] alu_out_r;

  // Shared adder (SUB as in_1 + ~in_2 + 1) and the ALU result mux.
  always_comb begin
    sub_s   = (bus.alu_op == OP_SUB);
    shamt_s = bus.in_2[4:0];
    if (sub_s) begin
      b_eff_s = ~bus.in_2;
    end else begin
      b_eff_s = bus.in_2;
    end
    sum_s = {1'b0, bus.in_1} + {1'b0, b_eff_s} + {{XLEN{1'b0}}, sub_s};
    case (bus.alu_op)
      OP_ADD, OP_SUB: result_s = sum_s[XLEN-1:0];
      OP_AND:         result_s = bus.in_1 & bus.in_2;
      OP_OR:          result_s = bus.in_1 | bus.in_2;
      OP_XOR:         result_s = bus.in_1 ^ bus.in_2;
      OP_SLL:         result_s = bus.in_1 << shamt_s;
      OP_SRL:         result_s = bus.in_1 >> shamt_s;
      OP_SRA:         result_s = $unsigned($signed(bus.in_1) >>> shamt_s);
      OP_SLT:         result_s = {{(XLEN-1){1'b0}}, ($signed(bus.in_1) < $signed(bus.in_2))};
      OP_SLTU:        result_s = {{(XLEN-1){1'b0}}, (bus.in_1 < bus.in_2)};
      OP_PASS_B:      result_s = bus.in_2;
      default:        result_s = {XLEN{1'b0}};
    endcase
  end

  // Flags; carry/overflow only mean something for the adder ops.
  always_comb begin
    arith_s = (bus.alu_op == OP_ADD) || (bus.alu_op == OP_SUB);
    zero_s  = (result_s == {XLEN{1'b0}});
    sign_s  = result_s[MSB];
    if (arith_s) begin
      carry_s    = sum_s[XLEN];
      // Using the effective B operand folds the ADD and SUB rules into one.
      overflow_s = (bus.in_1[MSB] == b_eff_s[MSB]) && (sum_s[MSB] != bus.in_1[MSB]);
    end else begin
      carry_s    = 1'b0;
      overflow_s = 1'b0;
    end
  end

  // Branch decision from the flags of the SUB issued by the control unit.
  always_comb begin
    case (bus.branch)
      BR_BEQ:  taken_s = zero_s;
      BR_BNE:  taken_s = ~zero_s;
      BR_NONE: taken_s = 1'b0;
      BR_JUMP: taken_s = 1'b1;
      BR_BLT:  taken_s = sign_s ^ overflow_s;
      BR_BGE:  taken_s = ~(sign_s ^ overflow_s);
      BR_BLTU: taken_s = ~carry_s;
      BR_BGEU: taken_s = carry_s;
      default: taken_s = 1'b0;
    endcase
  end

  // Redirect address, computed whether or not the branch is taken.
  always_comb begin
    jalr_sum_s = bus.rs1 + bus.imm;
    if (bus.jalr) begin
      target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
    end else begin
      target_s = bus.pc + bus.imm;
    end
  end

  // EX/MEM copy of the ALU result, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r <= {XLEN{1'b0}};
    end else begin
      alu_out_r <= result_s;
    end
  end

  assign bus.alu_out   = result_s;
  assign bus.zero      = zero_s;
  assign bus.carry     = carry_s;
  assign bus.overflow  = overflow_s;
  assign bus.sign      = sign_s;
  assign bus.taken     = taken_s;
  assign bus.target    = target_s;
  assign bus.alu_out_q = alu_out_r;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed vectors plus random vectors
// against a reference model, with a scoreboard of expected results.
module tb_ex_stage_unit;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        sign;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t        comb_q[$];
  logic [31:0] reg_q[$];

  ex_stage_unit_if #(.XLEN(32)) bus ();

  ex_stage_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] br, input logic j, input logic [31:0] pcv,
                                 input logic [31:0] immv, input logic [31:0] rs1v);
    exp_t        e;
    logic [63:0] us;
    longint      sa, sb, sr;
    logic [4:0]  sh;
    logic [31:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    case (op)
      4'd0: begin
        us = {32'd0, a} + {32'd0, b};
        e.alu = us[31:0];
        e.carry = us[32];
        sr = sa + sb;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        e.alu = a - b;
        e.carry = (a >= b);
        sr = sa - sb;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: e.alu = a & b;
      4'd3: e.alu = a | b;
      4'd4: e.alu = a ^ b;
      4'd5: e.alu = a << sh;
      4'd6: e.alu = a >> sh;
      4'd7: begin
        e.alu = a >> sh;
        if (a[31] && (sh != 5'd0)) e.alu = e.alu | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8:  e.alu = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  e.alu = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.alu = b;
      default: e.alu = 32'd0;
    endcase
    e.zero = (e.alu == 32'd0);
    e.sign = e.alu[31];
    case (br)
      3'd0: e.taken = e.zero;
      3'd1: e.taken = !e.zero;
      3'd2: e.taken = 1'b0;
      3'd3: e.taken = 1'b1;
      3'd4: e.taken = e.sign ^ e.ovf;
      3'd5: e.taken = !(e.sign ^ e.ovf);
      3'd6: e.taken = !e.carry;
      default: e.taken = e.carry;
    endcase
    if (j) begin
      t = rs1v + immv;
      e.target = t & 32'hFFFF_FFFE;
    end else begin
      e.target = pcv + immv;
    end
    return e;
  endfunction

  // Drive one vector on the falling edge, check combinational outputs, then
  // check the registered result after the next rising edge.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] br, input logic j, input logic [31:0] pcv,
                       input logic [31:0] immv, input logic [31:0] rs1v);
    exp_t e;
    exp_t m;
    @(negedge clk);
    bus.alu_op = op; bus.in_1 = a; bus.in_2 = b; bus.branch = br;
    bus.jalr = j; bus.pc = pcv; bus.imm = immv; bus.rs1 = rs1v;
    m = model(op, a, b, br, j, pcv, immv, rs1v);
    comb_q.push_back(m);
    reg_q.push_back(m.alu);
    #1;
    e = comb_q.pop_front();
    check_val("alu_out", bus.alu_out, e.alu);
    check_val("zero", {31'd0, bus.zero}, {31'd0, e.zero});
    check_val("carry", {31'd0, bus.carry}, {31'd0, e.carry});
    check_val("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
    check_val("sign", {31'd0, bus.sign}, {31'd0, e.sign});
    check_val("taken", {31'd0, bus.taken}, {31'd0, e.taken});
    check_val("target", bus.target, e.target);
    @(posedge clk);
    #1;
    check_val("alu_out_q", bus.alu_out_q, reg_q.pop_front());
  endtask

  logic [3:0]  sweep_op  [12];
  logic [31:0] sweep_exp [12];
  logic [31:0] br_exp;
  logic [31:0] ra, rb;

  initial begin
    sweep_op  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
    sweep_exp = '{32'hF0F0_0013, 32'hF0F0_000B, 32'h0000_0004, 32'hF0F0_000F,
                  32'hF0F0_000B, 32'h0F00_00F0, 32'h0F0F_0000, 32'hFF0F_0000,
                  32'h0000_0001, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000};
    // BEQ BNE NONE JUMP BLT BGE BLTU BGEU for -1 vs 1, bit i = branch code i
    br_exp = 32'b1001_1010;

    // Reset with the bubble encoding on the inputs.
    rst_n = 1'b0;
    bus.alu_op = 4'd0; bus.in_1 = 32'd0; bus.in_2 = 32'd0; bus.branch = 3'd2;
    bus.jalr = 1'b0; bus.pc = 32'd0; bus.imm = 32'd0; bus.rs1 = 32'd0;
    #3;
    check_val("rst_alu_out_q", bus.alu_out_q, 32'd0);
    check_val("bubble_taken", {31'd0, bus.taken}, 32'd0);
    check_val("bubble_alu_out", bus.alu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU op sweep
    for (int i = 0; i < 12; i++) begin
      apply(sweep_op[i], 32'hF0F0_000F, 32'h0000_0004, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
      check_val("sweep", bus.alu_out, sweep_exp[i]);
    end

    // Flag boundaries
    apply(4'd0, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("add_wrap_out", bus.alu_out, 32'd0);
    check_val("add_wrap_zero", {31'd0, bus.zero}, 32'd1);
    check_val("add_wrap_carry", {31'd0, bus.carry}, 32'd1);
    check_val("add_wrap_ovf", {31'd0, bus.overflow}, 32'd0);
    apply(4'd0, 32'h7FFF_FFFF, 32'd1, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("add_ovf", {31'd0, bus.overflow}, 32'd1);
    check_val("add_ovf_sign", {31'd0, bus.sign}, 32'd1);
    apply(4'd1, 32'd5, 32'd5, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("sub_eq_zero", {31'd0, bus.zero}, 32'd1);
    check_val("sub_eq_carry", {31'd0, bus.carry}, 32'd1);
    apply(4'd1, 32'h8000_0000, 32'd1, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("sub_ovf_out", bus.alu_out, 32'h7FFF_FFFF);
    check_val("sub_ovf", {31'd0, bus.overflow}, 32'd1);
    apply(4'd5, 32'h0000_0001, 32'd33, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("sll_shamt_wrap", bus.alu_out, 32'h0000_0002);
    apply(4'd7, 32'h8000_0000, 32'd31, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("sra_fill", bus.alu_out, 32'hFFFF_FFFF);

    // Branches with SUB, -1 vs 1
    for (int b = 0; b < 8; b++) begin
      apply(4'd1, 32'hFFFF_FFFF, 32'd1, 3'(b), 1'b0, 32'd0, 32'd0, 32'd0);
      check_val("branch_neg", {31'd0, bus.taken}, {31'd0, br_exp[b]});
    end
    apply(4'd1, 32'd7, 32'd7, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("beq_eq", {31'd0, bus.taken}, 32'd1);
    apply(4'd1, 32'd7, 32'd7, 3'd1, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("bne_eq", {31'd0, bus.taken}, 32'd0);

    // Targets
    apply(4'd0, 32'd0, 32'd0, 3'd3, 1'b0, 32'h0000_0100, 32'hFFFF_FFF8, 32'd0);
    check_val("target_pc", bus.target, 32'h0000_00F8);
    apply(4'd0, 32'd0, 32'd0, 3'd3, 1'b1, 32'h0000_0100, 32'd4, 32'h0000_0203);
    check_val("target_jalr", bus.target, 32'h0000_0206);
    apply(4'd0, 32'd0, 32'd0, 3'd3, 1'b0, 32'hFFFF_FFFC, 32'd8, 32'd0);
    check_val("target_wrap", bus.target, 32'h0000_0004);

    // Register and asynchronous reset
    apply(4'd0, 32'd2, 32'd3, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    check_val("reg_capture", bus.alu_out_q, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", bus.alu_out_q, 32'd0);
    @(posedge clk);
    #1;
    check_val("reset_hold", bus.alu_out_q, 32'd0);
    check_val("reset_comb", bus.alu_out, 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("release_no_capture", bus.alu_out_q, 32'd0);
    @(posedge clk);
    #1;
    check_val("release_capture", bus.alu_out_q, 32'd5);

    // Random vectors
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      apply(4'($urandom_range(0, 15)), ra, rb, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_unit.md
Name: ex_stage_unit

Overview:
- Execute-stage compute block of the 5-stage RV32I pipeline.
- Combines three parts:
  - a 32-bit ALU with zero/carry/overflow/sign flags;
  - branch-condition evaluation from those flags;
  - branch/jump target generation.
- Its combinational taken/target outputs drive the PC redirect and the IF/ID and ID/EX flush.
- A registered copy of the ALU result feeds the EX/MEM stage.

Parameters:
- XLEN, 32, datapath width; only 32 is required to work.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_op  input  4  ALU operation select
- in_1  input  32  ALU operand A (forwarded rs1 or PC, muxed upstream)
- in_2  input  32  ALU operand B (forwarded rs2, immediate, or 4)
- branch  input  3  branch type select
- jalr  input  1  1 = JALR target form
- pc  input  32  PC of the instruction in EX
- imm  input  32  sign-extended immediate
- rs1  input  32  forwarded rs1 value, used for the JALR target
- alu_out  output  32  combinational ALU result
- zero  output  1  alu_out == 0
- carry  output  1  carry flag
- overflow  output  1  signed-overflow flag
- sign  output  1  alu_out[31]
- taken  output  1  combinational redirect request
- target  output  32  combinational redirect address
- alu_out_q  output  32  alu_out registered on the rising edge of clk

Behaviour:
- ALU (combinational; shift amount = in_2[4:0]):
  - 0 ADD: in_1 + in_2.
  - 1 SUB: in_1 - in_2.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SLL, 6 SRL (logical), 7 SRA (arithmetic).
  - 8 SLT: signed compare, result 1 or 0.
  - 9 SLTU: unsigned compare, result 1 or 0.
  - 10 PASS_B: in_2 (used for LUI).
  - 11-15: result 0.
- Flags:
  - zero = (alu_out == 0) for every op.
  - sign = alu_out[31] for every op.
  - ADD: carry = bit 32 of the 33-bit sum; overflow = operands have the same sign and the result sign differs.
  - SUB: computed as in_1 + ~in_2 + 1; carry = bit 32 (1 means in_1 >= in_2 unsigned, i.e. no borrow); overflow = operand signs differ and the result sign differs from in_1.
  - All other ops: carry = 0, overflow = 0.
- Branch control (combinational). The branch code matches RV funct3 where defined; the control unit issues SUB for all conditional branches.
  - 0 BEQ: taken = zero.
  - 1 BNE: taken = !zero.
  - 2 NONE: taken = 0 (this is the bubble/reset encoding).
  - 3 JUMP: taken = 1 (JAL/JALR).
  - 4 BLT: taken = sign ^ overflow.
  - 5 BGE: taken = !(sign ^ overflow).
  - 6 BLTU: taken = !carry.
  - 7 BGEU: taken = carry.
- Target generation (combinational, computed regardless of taken):
  - jalr = 0: target = pc + imm.
  - jalr = 1: target = (rs1 + imm) with bit 0 cleared.
  - Sums wrap modulo 2^32.
- Register:
  - alu_out_q <= alu_out on every rising edge of clk.
  - rst_n low forces alu_out_q = 0 immediately, without waiting for a clock edge.
  - alu_out_q holds 0 while rst_n is low; capture resumes at the first rising edge after release.
- Reset scope:
  - Combinational outputs are unaffected by reset and follow their inputs.
  - The upstream ID/EX reset/bubble state (branch = 2, alu_op = 0, operands 0) yields taken = 0 and alu_out = 0.
- Latency: alu_out, flags, taken and target are valid in the same cycle as their inputs (zero latency); alu_out_q lags alu_out by one cycle.
- Boundary conditions:
  - ADD 0xFFFFFFFF + 1 gives 0 with carry = 1, zero = 1, overflow = 0.
  - SUB 0x80000000 - 1 gives 0x7FFFFFFF with overflow = 1.
  - Shift amounts of 32 or more use only the low 5 bits.
  - SRA of a negative value fills with ones.
  - Wrap-around of target is permitted.

Test Plan:
- ALU op sweep: in_1 = 0xF0F0000F, in_2 = 0x00000004, ops 0-10 -> respectively:
  - ADD 0xF0F00013, SUB 0xF0F0000B, AND 0x4, OR 0xF0F0000F, XOR 0xF0F0000B;
  - SLL 0x0F0000F0, SRL 0x0F0F0000, SRA 0xFF0F0000;
  - SLT 1, SLTU 0, PASS_B 0x4;
  - op 15 gives 0.
- Flags:
  - ADD 0xFFFFFFFF + 1 -> alu_out 0, zero 1, carry 1, overflow 0.
  - ADD 0x7FFFFFFF + 1 -> overflow 1, sign 1.
  - SUB 5 - 5 -> zero 1, carry 1.
- Branches, all with op SUB:
  - in_1 = -1, in_2 = 1: BLT taken 1, BGE 0, BLTU 0, BGEU 1, BEQ 0, BNE 1.
  - in_1 = in_2 = 7: BEQ 1, BNE 0.
  - branch = 2 -> taken 0; branch = 3 -> taken 1.
- Target:
  - pc = 0x100, imm = 0xFFFFFFF8, jalr = 0 -> target 0xF8.
  - rs1 = 0x203, imm = 4, jalr = 1 -> target 0x206.
- Register/reset:
  - drive ADD 2 + 3, clock once -> alu_out_q = 5.
  - assert rst_n low mid-cycle -> alu_out_q = 0 before the next edge.
  - release rst_n -> capture resumes at the next edge.
- Random: 1000 random operand/op/branch vectors against a reference model, checking all combinational outputs and alu_out_q.
